// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a shared-bus multi-digit 7-segment
//   display. Holds a shadow copy of per-digit nibbles, decimal points and
//   enables. Each digit slot starts with a blanking guard, and the nibble is
//   decoded internally. New contents arrive over valid/ready and are only
//   committed at a frame boundary, so a frame is never torn.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   load_valid   new display contents offered
//   load_ready   controller can accept contents (low while a load is pending)
//   load_data    hex nibble per digit, digit i = bits [4i+3:4i]
//   load_dp      decimal point per digit, 1 = lit
//   load_en      digit enable, 0 = digit always dark
//   io_sel       digit select, active-low, bit i = digit i
//   io_seg       segments, active-low: bit0=a .. bit6=g, bit7=dp
//   frame_start  one-cycle pulse on the first output cycle of the digit 0 slot
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_en,
  output logic [DIGITS-1:0]     io_sel,
  output logic [7:0]            io_seg,
  output logic                  frame_start
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Hex nibble to active-high segments, g..a order.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic                 pend_q, pend_d;
  logic [4*DIGITS-1:0]  pend_data_q, pend_data_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]    pend_en_q, pend_en_d;

  logic [4*DIGITS-1:0]  shd_data_q, shd_data_d;
  logic [DIGITS-1:0]    shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]    shd_en_q, shd_en_d;

  logic [DIGITS-1:0]    sel_q, sel_d;
  logic [7:0]           seg_q, seg_d;
  logic                 fs_q, fs_d;

  logic                 slot_end_s;
  logic                 commit_s;
  logic                 xfer_s;
  logic [DIGITS-1:0]    supp_s;
  logic [3:0]           cur_nib_s;

  assign slot_end_s = (cnt_q == CNT_LAST);
  assign commit_s   = slot_end_s && (idx_q == IDX_LAST);
  assign xfer_s     = load_valid && !pend_q;

  assign load_ready  = ~pend_q;
  assign io_sel      = sel_q;
  assign io_seg      = seg_q;
  assign frame_start = fs_q;

  // Free-running slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (slot_end_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Blank/drive next state; state_q always matches the phase of cnt_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_d == CNT_DRIVE) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (slot_end_s) begin
          state_d = ST_BLANK;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Pending register capture and frame-boundary commit into the shadow.
  // A transfer accepted on the commit cycle only fills pending; it waits
  // for the following commit point.
  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_en_d    = shd_en_q;
    if (commit_s && pend_q) begin
      shd_data_d = pend_data_q;
      shd_dp_d   = pend_dp_q;
      shd_en_d   = pend_en_q;
      pend_d     = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (xfer_s) begin
      pend_d      = 1'b1;
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_en_d   = load_en;
    end else begin
      pend_data_d = pend_data_q;
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp_s   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run  = zero_run & (shd_data_q[4*k +: 4] == 4'h0);
      supp_s[k] = (LZ_SUPPRESS != 0) && (k > 0) && zero_run;
    end
  end

  // Next registered outputs from the current state, counter and shadow.
  always_comb begin
    cur_nib_s = shd_data_q[{idx_q, 2'b00} +: 4];
    sel_d     = '1;
    seg_d     = 8'hFF;
    fs_d      = (cnt_q == '0) && (idx_q == '0);
    if ((state_q == ST_DRIVE) && shd_en_q[idx_q] && !supp_s[idx_q]) begin
      sel_d = ~(DIGITS'(1) << idx_q);
      seg_d = ~{shd_dp_q[idx_q], hex7(cur_nib_s)};
    end else begin
      sel_d = '1;
      seg_d = 8'hFF;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, handshake/shadow storage and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      shd_data_q  <= '0;
      shd_dp_q    <= '0;
      shd_en_q    <= '0;
      sel_q       <= '1;
      seg_q       <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      shd_data_q  <= shd_data_d;
      shd_dp_q    <= shd_dp_d;
      shd_en_q    <= shd_en_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (leading-zero suppression off/on)
// share one stimulus. A cycle model pushes expected outputs into a queue
// before each clock edge; they are popped and compared just after the edge.
module tb_seg_scan_ctrl;

  localparam int DIG   = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_en;

  logic        load_ready0, load_ready1;
  logic [3:0]  io_sel0, io_sel1;
  logic [7:0]  io_seg0, io_seg1;
  logic        frame_start0, frame_start1;

  int n_vec;
  int n_bad;

  seg_scan_ctrl #(.DIGITS(DIG), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
    .load_data(load_data), .load_dp(load_dp), .load_en(load_en),
    .io_sel(io_sel0), .io_seg(io_seg0), .frame_start(frame_start0)
  );

  seg_scan_ctrl #(.DIGITS(DIG), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
    .load_data(load_data), .load_dp(load_dp), .load_en(load_en),
    .io_sel(io_sel1), .io_seg(io_seg1), .frame_start(frame_start1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel0;
    logic [7:0] seg0;
    logic [3:0] sel1;
    logic [7:0] seg1;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state (value before the upcoming clock edge)
  int          m_cnt;
  int          m_idx;
  bit          m_pend;
  logic [15:0] m_pd, m_sd;
  logic [3:0]  m_pdp, m_pen, m_sdp, m_sen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] drive_exp(input bit lz);
    logic [3:0] nib;
    logic [15:0] upper;
    bit supp;
    nib   = m_sd[m_idx*4 +: 4];
    upper = m_sd >> (4 * m_idx);
    supp  = lz && (m_idx > 0) && (upper == 16'h0);
    if (m_cnt < BLANK || !m_sen[m_idx] || supp) return {4'hF, 8'hFF};
    return {~(4'b0001 << m_idx), ~{m_sdp[m_idx], hex_tbl[nib]}};
  endfunction

  task automatic cycle();
    exp_t e;
    bit commit, xfer;
    logic [11:0] d0, d1;
    if (rst) begin
      e = '{4'hF, 8'hFF, 4'hF, 8'hFF, 1'b0, 1'b1};
      m_cnt = 0; m_idx = 0; m_pend = 0;
      m_pd = '0; m_pdp = '0; m_pen = '0;
      m_sd = '0; m_sdp = '0; m_sen = '0;
    end else begin
      d0 = drive_exp(1'b0);
      d1 = drive_exp(1'b1);
      e.sel0 = d0[11:8]; e.seg0 = d0[7:0];
      e.sel1 = d1[11:8]; e.seg1 = d1[7:0];
      e.fs   = (m_cnt == 0) && (m_idx == 0);
      commit = (m_cnt == SLOT - 1) && (m_idx == DIG - 1);
      xfer   = load_valid && !m_pend;
      if (commit && m_pend) begin
        m_sd = m_pd; m_sdp = m_pdp; m_sen = m_pen; m_pend = 0;
      end
      if (xfer) begin
        m_pend = 1; m_pd = load_data; m_pdp = load_dp; m_pen = load_en;
      end
      e.rdy = !m_pend;
      if (m_cnt == SLOT - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == DIG - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sel0", io_sel0, e.sel0);
    check_eq("seg0", io_seg0, e.seg0);
    check_eq("sel1_lz", io_sel1, e.sel1);
    check_eq("seg1_lz", io_seg1, e.seg1);
    check_eq("frame_start", frame_start0, e.fs);
    check_eq("load_ready", load_ready0, e.rdy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (load_ready0 === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check_eq("ready_wait", ok, 1);
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (frame_start0 === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check_eq("fs_wait", ok, 1);
  endtask

  task automatic wait_model(input int idx, input int cnt);
    for (int i = 0; i < 40; i++) begin
      if (m_idx == idx && m_cnt == cnt) break;
      cycle();
    end
  endtask

  task automatic load_once(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    load_data = d; load_dp = dp; load_en = en; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
  endtask

  initial begin
    int fs_cnt;
    int lit_cnt;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0; load_en = '0;
    m_cnt = 0; m_idx = 0; m_pend = 0;
    m_pd = '0; m_pdp = '0; m_pen = '0; m_sd = '0; m_sdp = '0; m_sen = '0;

    // 1: reset and idle
    run(3);
    check_eq("rst_sel", io_sel0, 4'hF);
    check_eq("rst_seg", io_seg0, 8'hFF);
    rst = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (frame_start0) fs_cnt++;
    end
    check_eq("idle_fs_count", fs_cnt, 2);

    // 2/3: first load, second offered while pending
    load_once(16'h12AF, 4'b0100, 4'hF);
    check_eq("ready_low_after_load", load_ready0, 1'b0);
    cycle();
    load_data = 16'h3456; load_dp = 4'b0000; load_en = 4'hF; load_valid = 1'b1;
    wait_ready();
    cycle();
    check_eq("fs_new_frame", frame_start0, 1'b1);
    load_valid = 1'b0;
    run(2);
    check_eq("d0_sel", io_sel0, 4'b1110);
    check_eq("d0_seg", io_seg0, 8'h8E);
    run(16);
    check_eq("d2_sel", io_sel0, 4'b1011);
    check_eq("d2_seg_dp", io_seg0, 8'h24);
    run(6);
    check_eq("blank_sel", io_sel0, 4'hF);
    check_eq("blank_seg", io_seg0, 8'hFF);
    run(2);
    check_eq("d3_sel", io_sel0, 4'b0111);
    check_eq("d3_seg", io_seg0, 8'hF9);
    wait_ready();
    cycle();
    run(2);
    check_eq("second_d0_seg", io_seg0, 8'h82);

    // 4: valid exactly on the commit cycle
    wait_model(DIG - 1, SLOT - 1);
    load_once(16'hC0DE, 4'b0000, 4'hF);
    cycle();
    check_eq("fs_after_commit_load", frame_start0, 1'b1);
    run(2);
    check_eq("late_load_not_yet", io_seg0, 8'h82);
    wait_ready();
    cycle();
    run(2);
    check_eq("late_load_shown", io_seg0, 8'h86);

    // 5: leading-zero suppression
    load_once(16'h0070, 4'b0000, 4'hF);
    wait_ready();
    cycle();
    run(2);
    check_eq("lz_d0_sel", io_sel1, 4'b1110);
    check_eq("lz_d0_seg", io_seg1, 8'hC0);
    run(8);
    check_eq("lz_d1_sel", io_sel1, 4'b1101);
    check_eq("lz_d1_seg", io_seg1, 8'hF8);
    run(8);
    check_eq("lz_d2_dark", io_sel1, 4'hF);
    check_eq("nolz_d2_seg", io_seg0, 8'hC0);
    run(8);
    check_eq("lz_d3_dark", io_seg1, 8'hFF);

    // 6: reset mid-drive of digit 2 with a pending load
    wait_fs();
    load_once(16'h8888, 4'hF, 4'hF);
    wait_model(2, 4);
    rst = 1'b1;
    cycle();
    check_eq("rst_ready", load_ready0, 1'b1);
    check_eq("rst_mid_sel", io_sel0, 4'hF);
    check_eq("rst_mid_fs", frame_start0, 1'b0);
    rst = 1'b0;
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (io_sel0 != 4'hF) lit_cnt++;
    end
    check_eq("discarded_never_lit", lit_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
